// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: MemOp codes, FSM states, defaults.
package mem_pkg;

    localparam int unsigned WAIT_MAX_DEFAULT = 15;

    typedef enum logic [2:0] {
        OpWord  = 3'b000,
        OpHalfS = 3'b001,
        OpHalfU = 3'b010,
        OpByteS = 3'b011,
        OpByteU = 3'b100
    } mem_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } mem_state_e;

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == OpHalfS) || (op == OpHalfU);
    endfunction

    function automatic logic op_is_byte(input logic [2:0] op);
        return (op == OpByteS) || (op == OpByteU);
    endfunction

    // Unlisted encodings fall back to word size, so they demand word alignment.
    function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] lane);
        if (op_is_byte(op)) begin
            return 1'b1;
        end else if (op_is_half(op)) begin
            return ~lane[0];
        end
        return lane == 2'b00;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data aligner: picks the addressed byte/half lane (little-endian) and extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_op,
    output logic [31:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        unique case (addr)
            2'b00: byte_sel = rdata[7:0];
            2'b01: byte_sel = rdata[15:8];
            2'b10: byte_sel = rdata[23:16];
            2'b11: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        aligned = rdata;
        case (mem_op)
            OpHalfS: aligned = {{16{half_sel[15]}}, half_sel};
            OpHalfU: aligned = {16'h0000, half_sel};
            OpByteS: aligned = {{24{byte_sel[7]}}, byte_sel};
            OpByteU: aligned = {24'h000000, byte_sel};
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues req/ack bus transactions, stalls the pipe while
// outstanding, aligns load data into Mem_dataout and flags misalignment and timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_valid,
    input  logic        Mem_MemRd,
    input  logic        Mem_MemWr,
    input  logic [2:0]  Mem_MemOp,
    input  logic [31:0] Mem_ALUout,
    input  logic [31:0] Mem_busB,
    output logic [31:0] Mem_dataout,
    output logic        mem_stall,
    output logic        mem_addr_err,
    output logic        mem_bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [29:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam logic [7:0] CntLast = 8'(WAIT_MAX - 1);

    mem_state_e  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;

    logic        access;
    logic        aligned_ok;
    logic        start;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] load_data;

    assign access       = Mem_valid & (Mem_MemRd | Mem_MemWr);
    assign aligned_ok   = op_aligned(Mem_MemOp, Mem_ALUout[1:0]);
    assign start        = access & aligned_ok & (state == StIdle);
    assign mem_addr_err = access & ~aligned_ok;
    assign mem_stall    = start | (state == StBusy);

    // Store lane steering; a load (including MemRd-only) reads all four lanes.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = 32'h0000_0000;
        if (Mem_MemWr) begin
            if (op_is_byte(Mem_MemOp)) begin
                be_n    = 4'b0001 << Mem_ALUout[1:0];
                wdata_n = {4{Mem_busB[7:0]}};
            end else if (op_is_half(Mem_MemOp)) begin
                be_n    = Mem_ALUout[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{Mem_busB[15:0]}};
            end else begin
                wdata_n = Mem_busB;
            end
        end
    end

    mem_load_align u_align (
        .rdata   (dm_rdata),
        .addr    (lane_q),
        .mem_op  (op_q),
        .aligned (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            wait_cnt    <= 8'd0;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 30'd0;
            dm_be       <= 4'b0000;
            dm_wdata    <= 32'h0000_0000;
            Mem_dataout <= 32'h0000_0000;
            mem_bus_err <= 1'b0;
        end else begin
            mem_bus_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        dm_req   <= 1'b1;
                        dm_we    <= Mem_MemWr;
                        dm_addr  <= Mem_ALUout[31:2];
                        dm_be    <= be_n;
                        dm_wdata <= wdata_n;
                        op_q     <= Mem_MemOp;
                        lane_q   <= Mem_ALUout[1:0];
                        wait_cnt <= 8'd0;
                        state    <= StBusy;
                    end
                end
                StBusy: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) begin
                            Mem_dataout <= load_data;
                        end
                        state <= StDone;
                    end else if (wait_cnt == CntLast) begin
                        dm_req      <= 1'b0;
                        Mem_dataout <= 32'h0000_0000;
                        mem_bus_err <= 1'b1;
                        state       <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                // One unstalled cycle lets MEM/WB capture the result; no relaunch here.
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the 5-stage MIPS pipeline; sits between the EX/MEM register and the MEM/WB register.
- Drives a req/ack data-memory bus with byte enables.
- Aligns and extends load data into Mem_dataout, which feeds the MEM/WB register.
- Stalls the pipeline while a bus transaction is outstanding; flags misalignment and bus timeout.

Parameters:
WAIT_MAX, 15, max BUSY cycles without dm_ack before timeout (1..255)

Ports:
clk  in  1  pipeline clock, posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
Mem_valid  in  1  instruction in MEM stage is valid (not bubble/flushed)
Mem_MemRd  in  1  load
Mem_MemWr  in  1  store
Mem_MemOp  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned (stores use 000/001/011)
Mem_ALUout  in  32  effective byte address
Mem_busB  in  32  store data
Mem_dataout  out  32  aligned/extended load result, registered
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
mem_addr_err  out  1  misaligned access, combinational
mem_bus_err  out  1  timeout pulse, registered
dm_req  out  1  bus request
dm_we  out  1  1 = write
dm_addr  out  30  word address (byte address [31:2])
dm_be  out  4  byte enables, little-endian lanes
dm_wdata  out  32  write data
dm_ack  in  1  slave completion, one-cycle pulse
dm_rdata  in  32  read data, valid with dm_ack

Behaviour:
Reset (asynchronous, rst=0):
- state=IDLE, wait counter=0.
- dm_req, dm_we, dm_be, dm_addr, dm_wdata, Mem_dataout, mem_bus_err all 0.
- Reset mid-transaction drops dm_req immediately; the slave must tolerate an abandoned request.

Start condition:
- start = Mem_valid & (Mem_MemRd | Mem_MemWr) & aligned & state==IDLE.
- Both MemRd and MemWr high: treated as store.

Alignment:
- Word requires addr[1:0]==00; half requires addr[0]==0; byte is always aligned.
- Misaligned access: mem_addr_err=1 (combinational), no request, no stall, Mem_dataout unchanged.

States:
- IDLE
  - On start: capture dm_addr, dm_we, dm_be, dm_wdata, MemOp, addr[1:0]; counter=0; dm_req=1; go to BUSY.
  - mem_stall=1 combinationally during the start cycle.
- BUSY
  - mem_stall=1; dm_req and all captured bus outputs held stable.
  - dm_ack sampled at posedge: dm_req=0; for a load, Mem_dataout=aligned(dm_rdata); go to DONE.
  - No ack and counter==WAIT_MAX-1: dm_req=0, Mem_dataout=0, mem_bus_err=1, go to DONE. Otherwise counter+1.
- DONE
  - mem_stall=0 for exactly one cycle, so the pipeline advances and MEM/WB captures Mem_dataout.
  - Next edge: mem_bus_err=0, go to IDLE. A start is never evaluated in DONE, so the same instruction is not relaunched.

Stall length:
- Minimum (ack in first BUSY cycle): 2 stall cycles, then DONE.
- Store: Mem_dataout unchanged.
- dm_ack seen in IDLE/DONE is ignored.

Store lanes:
- sw: be=1111, wdata=busB.
- sh: be=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{busB[15:0]}}.
- sb: be=0001<<addr[1:0], wdata={4{busB[7:0]}}.
- Loads: be=1111, wdata=0.

Load extraction:
- Byte lane = addr[1:0], half lane = addr[1]; little-endian.
- Signed ops sign-extend to 32 bits, unsigned ops zero-extend.

Decomposition:
- Shared package mem_pkg: MemOp encodings, FSM state encoding (IDLE/BUSY/DONE), default WAIT_MAX.
- One combinational sub-module, mem_load_align: inputs rdata, addr[1:0], MemOp; output aligned 32-bit result. Reused by the bench as the reference model.

Test Plan:
- Load, zero-wait: lb at 0x1003, dm_rdata=0x80FF_1234, ack in first BUSY cycle -> stall 2 cycles, Mem_dataout=0xFFFF_FF80; lbu same -> 0x0000_0080; lhu at 0x1002 -> 0x0000_80FF.
- Store lanes: sh at 0x2002, busB=0xDEAD_BEEF -> dm_addr=0x800, be=1100, wdata=0xBEEF_BEEF, we=1; sb at 0x2001 -> be=0010, wdata=0xEFEF_EFEF.
- Wait states: lw at 0x3000, ack after 4 BUSY cycles -> mem_stall high 5 cycles, dm_req/addr stable throughout, DONE 1 cycle, Mem_dataout=rdata.
- Timeout: WAIT_MAX=15, no ack -> dm_req drops after 15 BUSY cycles, mem_bus_err pulses 1 cycle, Mem_dataout=0.
- Misaligned: lw at 0x4002 -> mem_addr_err=1, dm_req=0, mem_stall=0.
- Reset mid-BUSY: rst=0 two cycles into wait -> dm_req=0 asynchronously, state IDLE; spurious dm_ack after reset ignored; a following lw completes normally.
